// File: rtl/cdc_sched_pkg.sv
// Shared types and default sizing for the clk_a side of the multi-bit CDC channel.
package cdc_sched_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      RELEASE = 2'd2
   } sched_state_e;

   localparam int NREQ_DEF    = 4;
   localparam int DW_DEF      = 4;
   localparam int TIMEOUT_DEF = 255;
   localparam int TCNT_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser, 1 bit, async active-low reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic arstn,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/cdc_tx_scheduler.sv
// Source-side CDC scheduler: round-robin pick of NREQ requesters, word held
// stable on cdc_data_o for the whole four-phase req/ack transfer.
//
// state   | meaning
// IDLE    | waiting for a request with the synchronised ack low
// SEND    | cdc_req_o high, data held, waiting for ack or timeout
// RELEASE | cdc_req_o low, waiting for the far side to drop ack
module cdc_tx_scheduler
   import cdc_sched_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk_a,
   input  logic               arstn,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] data_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic               cdc_req_o,
   output logic [DW-1:0]      cdc_data_o,
   input  logic               cdc_ack_i,
   output logic               busy_o,
   output logic               err_o,
   output logic [15:0]        xfer_cnt_o
);

   localparam int PW = $clog2(NREQ);

   sched_state_e      state_q;
   logic [PW-1:0]     ptr_q;
   logic [TCNT_W-1:0] tcnt_q;
   logic              cdc_req_q;
   logic [DW-1:0]     cdc_data_q;
   logic [NREQ-1:0]   gnt_q;
   logic              err_q;
   logic              busy_q;
   logic [15:0]       xfer_cnt_q;

   logic              ack_s;
   logic              launch_d;
   logic [PW-1:0]     pick_idx_d;
   logic [DW-1:0]     pick_word_d;

   sync_2ff u_ack_sync (
      .clk   (clk_a),
      .arstn (arstn),
      .d_i   (cdc_ack_i),
      .q_o   (ack_s)
   );

   // Search starts just after the last winner, so the winner drops to lowest priority.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [PW-1:0]   ptr);
      logic [PW-1:0] g;
      logic          found;
      int            k;
      g     = ptr;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         k = (int'(ptr) + i) % NREQ;
         if (!found && req[k]) begin
            g     = PW'(k);
            found = 1'b1;
         end
      end
      return g;
   endfunction

   always_comb begin
      launch_d    = (|req_i) && !ack_s;
      pick_idx_d  = rr_pick(req_i, ptr_q);
      pick_word_d = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_idx_d == PW'(k)) pick_word_d = data_i[k*DW +: DW];
      end
   end

   always_ff @(posedge clk_a or negedge arstn) begin
      if (!arstn) begin
         state_q    <= IDLE;
         ptr_q      <= PW'(NREQ - 1);
         tcnt_q     <= '0;
         cdc_req_q  <= 1'b0;
         cdc_data_q <= '0;
         gnt_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         gnt_q <= '0;
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (launch_d) begin
                  cdc_data_q <= pick_word_d;
                  ptr_q      <= pick_idx_d;
                  gnt_q      <= NREQ'(1) << pick_idx_d;
                  cdc_req_q  <= 1'b1;
                  tcnt_q     <= TCNT_W'(TIMEOUT);
                  busy_q     <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (ack_s) begin
                  cdc_req_q  <= 1'b0;
                  xfer_cnt_q <= xfer_cnt_q + 16'd1;
                  state_q    <= RELEASE;
               end else if (tcnt_q == '0) begin
                  cdc_req_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= RELEASE;
               end else begin
                  tcnt_q <= tcnt_q - 1'b1;
               end
            end
            RELEASE: begin
               if (!ack_s) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               cdc_req_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign cdc_req_o  = cdc_req_q;
   assign cdc_data_o = cdc_data_q;
   assign busy_o     = busy_q;
   assign err_o      = err_q;
   assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_cdc_tx_scheduler.sv
// Scoreboard bench for cdc_tx_scheduler: stimulus pushes expected grants, a
// monitor pops on every gnt_o pulse and checks the transfer through to IDLE.
module tb_cdc_tx_scheduler;

   localparam int NREQ = 4;
   localparam int DW   = 4;
   localparam int TO   = 15;

   logic        clk_a = 1'b0;
   logic        arstn = 1'b0;
   logic [3:0]  req_i = '0;
   logic [15:0] data_i = '0;
   logic        cdc_ack_i = 1'b0;
   logic [3:0]  gnt_o;
   logic        cdc_req_o;
   logic [3:0]  cdc_data_o;
   logic        busy_o;
   logic        err_o;
   logic [15:0] xfer_cnt_o;

   cdc_tx_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TO)) dut (
      .clk_a      (clk_a),
      .arstn      (arstn),
      .req_i      (req_i),
      .data_i     (data_i),
      .gnt_o      (gnt_o),
      .cdc_req_o  (cdc_req_o),
      .cdc_data_o (cdc_data_o),
      .cdc_ack_i  (cdc_ack_i),
      .busy_o     (busy_o),
      .err_o      (err_o),
      .xfer_cnt_o (xfer_cnt_o)
   );

   initial forever #5 clk_a = ~clk_a;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   typedef struct {
      logic [3:0]  gnt;
      logic [3:0]  data;
      logic [15:0] cnt;
      bit          to;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: round-robin pointer and completed-transfer count.
   int m_ptr = NREQ - 1;
   int m_cnt = 0;

   function automatic int rr_model(input logic [3:0] r);
      for (int i = 1; i <= NREQ; i++) begin
         if (r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic push_exp(input logic [15:0] d, input int g, input bit to);
      exp_t e;
      e.gnt  = 4'(1 << g);
      e.data = 4'(d >> (g * DW));
      if (!to) m_cnt = (m_cnt + 1) % 65536;
      e.cnt  = 16'(m_cnt);
      e.to   = to;
      m_ptr  = g;
      exp_q.push_back(e);
   endtask

   // Far-side ack model: ack follows cdc_req_o delayed by ack_dly negedges.
   bit         ack_en    = 1'b1;
   bit         ack_force = 1'b0;
   int         ack_dly   = 3;
   logic [7:0] hist      = '0;

   initial forever begin
      @(negedge clk_a);
      if (!arstn) hist = '0;
      else        hist = {hist[6:0], cdc_req_o};
      cdc_ack_i = ack_force | (ack_en & hist[ack_dly]);
   end

   // Monitor
   bit   in_flight = 1'b0;
   exp_t cur;
   int   req_hi, err_seen, data_bad;

   initial forever begin
      @(negedge clk_a);
      if (!arstn) begin
         in_flight = 1'b0;
      end else begin
         if (gnt_o != '0) begin
            if (exp_q.size() == 0) begin
               chk("spurious_gnt", {28'd0, gnt_o}, 32'd0);
            end else begin
               cur = exp_q.pop_front();
               chk("gnt", {28'd0, gnt_o}, {28'd0, cur.gnt});
               chk("data_at_gnt", {28'd0, cdc_data_o}, {28'd0, cur.data});
               chk("req_at_gnt", {31'd0, cdc_req_o}, 32'd1);
               in_flight = 1'b1;
               req_hi    = 0;
               err_seen  = 0;
               data_bad  = 0;
            end
         end
         if (in_flight) begin
            if (cdc_req_o) req_hi++;
            if (err_o) err_seen++;
            if (cdc_data_o != cur.data) data_bad++;
            if (!busy_o) begin
               chk("xfer_cnt", {16'd0, xfer_cnt_o}, {16'd0, cur.cnt});
               chk("err_pulses", err_seen, cur.to ? 1 : 0);
               chk("data_stable", data_bad, 0);
               if (cur.to) chk("timeout_req_cycles", req_hi, TO + 1);
               in_flight = 1'b0;
            end
         end
      end
   end

   task automatic wait_launch();
      int n = 0;
      do begin @(negedge clk_a); n++; end while (!busy_o && n < 40);
      chk("launch_seen", {31'd0, busy_o}, 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (busy_o && n < 300) begin @(negedge clk_a); n++; end
      chk("back_to_idle", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic do_xfer(input logic [3:0] r, input logic [15:0] d, input int g,
                          input bit to, input bit drop);
      data_i = d;
      req_i  = r;
      push_exp(d, g, to);
      wait_launch();
      if (drop) begin
         req_i  = '0;
         data_i = 16'($urandom);
      end
      wait_done();
   endtask

   task automatic do_reset();
      @(negedge clk_a);
      arstn  = 1'b0;
      req_i  = '0;
      m_ptr  = NREQ - 1;
      m_cnt  = 0;
      repeat (3) @(negedge clk_a);
      arstn = 1'b1;
      @(negedge clk_a);
   endtask

   int fair_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int fair_b[4] = '{1, 3, 1, 3};

   initial begin
      int n;
      // Reset state
      repeat (2) @(negedge clk_a);
      chk("rst_gnt", {28'd0, gnt_o}, 32'd0);
      chk("rst_req", {31'd0, cdc_req_o}, 32'd0);
      chk("rst_data", {28'd0, cdc_data_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_cnt", {16'd0, xfer_cnt_o}, 32'd0);
      arstn = 1'b1;
      n = 0;
      repeat (5) begin @(negedge clk_a); if (busy_o) n++; end
      chk("idle_no_req", n, 0);

      // Single transfer
      ack_dly = 3;
      do_xfer(4'b0100, 16'h0A00, 2, 1'b0, 1'b1);

      // Fairness, all requesting
      do_reset();
      for (int i = 0; i < 8; i++) do_xfer(4'b1111, 16'h4321, fair_a[i], 1'b0, 1'b0);
      req_i = '0;

      // Fairness, 1010
      do_reset();
      for (int i = 0; i < 4; i++) do_xfer(4'b1010, 16'hB7C5, fair_b[i], 1'b0, 1'b0);
      req_i = '0;

      // Timeout
      ack_en = 1'b0;
      do_xfer(4'b0001, 16'h0009, rr_model(4'b0001), 1'b1, 1'b1);
      repeat (9) @(negedge clk_a);
      ack_en = 1'b1;

      // Stale ack blocks launch
      ack_en    = 1'b0;
      ack_force = 1'b1;
      repeat (4) @(negedge clk_a);
      data_i = 16'h5E3D;
      req_i  = 4'b0110;
      push_exp(16'h5E3D, rr_model(4'b0110), 1'b0);
      n = 0;
      repeat (8) begin @(negedge clk_a); if (busy_o || gnt_o != '0) n++; end
      chk("stale_ack_blocks", n, 0);
      #1 ack_force = 1'b0;
      ack_en = 1'b1;
      @(negedge clk_a);
      n = 0;
      while (gnt_o == '0 && n < 20) begin @(negedge clk_a); n++; end
      chk("stale_release_latency", n, 3);
      req_i = '0;
      wait_done();

      // Randomised transfers
      for (int t = 0; t < 40; t++) begin
         logic [3:0]  r;
         logic [15:0] d;
         bit          to;
         r       = 4'($urandom_range(1, 15));
         d       = 16'($urandom);
         to      = ($urandom_range(0, 5) == 0);
         ack_en  = !to;
         ack_dly = $urandom_range(0, 5);
         do_xfer(r, d, rr_model(r), to, 1'($urandom_range(0, 1)));
         if (to || $urandom_range(0, 3) == 0) begin
            req_i = '0;
            repeat (9) @(negedge clk_a);
         end
      end
      req_i = '0;
      ack_en = 1'b1;
      repeat (9) @(negedge clk_a);

      // Reset mid-SEND
      ack_en = 1'b0;
      data_i = 16'hFEDC;
      req_i  = 4'b1111;
      push_exp(16'hFEDC, rr_model(4'b1111), 1'b0);
      wait_launch();
      repeat (3) @(negedge clk_a);
      #2 arstn = 1'b0;
      #1;
      chk("async_rst_req", {31'd0, cdc_req_o}, 32'd0);
      chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("async_rst_cnt", {16'd0, xfer_cnt_o}, 32'd0);
      chk("async_rst_data", {28'd0, cdc_data_o}, 32'd0);
      m_ptr = NREQ - 1;
      m_cnt = 0;
      repeat (3) @(negedge clk_a);
      ack_en = 1'b1;
      arstn  = 1'b1;
      data_i = 16'h1234;
      push_exp(16'h1234, 0, 1'b0);
      wait_launch();
      req_i = '0;
      wait_done();

      repeat (5) @(negedge clk_a);
      chk("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cdc_tx_scheduler.md
# cdc_tx_scheduler

Source-side (clk_a) scheduler for the 4-bit multi-bit CDC channel: it arbitrates NREQ requesters round-robin and captures the winner's word into a stable holding register. It drives a four-phase req/ack handshake toward the clk_b capture logic. The block guarantees the CDC data bus is never changed while a transfer is in flight. It sits between clk_a producers and the clk_b enable-synchronised capture register.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 4: data word width
- TIMEOUT, 255: max clk_a cycles in SEND before abort (8-bit counter)
- clk_a  in  1  source clock
- arstn  in  1  asynchronous, active-low reset
- req_i  in  NREQ  per-requester level request
- data_i  in  NREQ*DW  packed words; requester k at [k*DW +: DW]
- gnt_o  out  NREQ  one-hot 1-cycle pulse: word k captured, req may drop
- cdc_req_o  out  1  handshake request to clk_b (flop output)
- cdc_data_o  out  DW  held word (flop output)
- cdc_ack_i  in  1  ack from clk_b domain (asynchronous to clk_a)
- busy_o  out  1  high when state is not IDLE
- err_o  out  1  1-cycle pulse on timeout abort
- xfer_cnt_o  out  16  completed transfers, wraps 0xFFFF->0

## Operation
- cdc_ack_i passes through a 2-flop synchroniser; ack_s is the second flop. Both flops reset to 0.
- States:
  - IDLE
    - If (|req_i) and ack_s==0: grant index g = first set bit at or after ptr+1 (mod NREQ).
    - Then cdc_data_o<=word g, ptr<=g, gnt_o[g]<=1, cdc_req_o<=1, tcnt<=0, go to SEND.
    - If ack_s==1, hold in IDLE; a stale ack blocks launch.
  - SEND
    - If ack_s==1: cdc_req_o<=0, xfer_cnt_o<=xfer_cnt_o+1, go to RELEASE.
    - Else if tcnt==TIMEOUT: cdc_req_o<=0, err_o<=1, go to RELEASE, no count increment.
    - Else tcnt<=tcnt+1.
  - RELEASE
    - If ack_s==0: go to IDLE.
    - No timeout in RELEASE.
- cdc_data_o changes only on the IDLE->SEND edge and stays stable through SEND and RELEASE.
- req_i is ignored outside IDLE. A requester still holding req after its gnt_o pulse is treated as a new request.
- Round-robin: the winner becomes lowest priority. With all requests permanently high, the order is 0,1,2,…,NREQ-1,0.
- Reset values:
  - state=IDLE
  - ptr=NREQ-1 (req 0 highest after reset)
  - cdc_req_o=0, cdc_data_o=0, gnt_o=0, err_o=0, xfer_cnt_o=0, tcnt=0
  - busy_o=0
- Reset mid-transfer: arstn low forces all of the above immediately (async). The clk_b side sees cdc_req_o fall and completes its own four-phase release.

## Timing
- req_i sampled high at edge N (IDLE, ack_s=0): cdc_req_o, cdc_data_o, gnt_o and busy_o are valid after edge N; gnt_o is high for exactly that one cycle.
- cdc_ack_i rising before edge M: ack_s=1 after edge M+1; cdc_req_o=0 after edge M+2.
- cdc_ack_i falling before edge P: ack_s=0 after P+1; IDLE after P+2; next launch possible at edge P+3.
- Minimum IDLE-to-IDLE with clk_b=clk_a and a 2-flop far side is about 10 cycles. The block imposes no throughput requirement.
- Timeout: cdc_req_o high for exactly TIMEOUT+1 cycles, then err_o pulses in the same cycle cdc_req_o falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package cdc_sched_pkg holds:
  - state enum {IDLE, SEND, RELEASE}
  - default NREQ/DW/TIMEOUT constants
- Sub-module sync_2ff (1-bit, async active-low reset) for cdc_ack_i; it is reused by the clk_b side.
- The round-robin picker is a function or combinational block inside the top; it is not a separate module.

## Test plan
- Reset check: hold arstn low -> all outputs 0; release with req_i=0 -> busy_o stays 0.
- Single transfer:
  - Stimulus: req_i=4'b0100, data word 2 = 4'hA, ack model with 3-cycle delay.
  - Response: gnt_o=4'b0100 for 1 cycle, cdc_data_o=4'hA stable until IDLE, xfer_cnt_o=1.
- Fairness:
  - Stimulus: req_i=4'b1111 held, 8 transfers.
  - Response: gnt_o order is 0,1,2,3,0,1,2,3.
  - Stimulus: req_i=4'b1010 after reset.
  - Response: order is 1,3,1,3.
- Timeout:
  - Stimulus: TIMEOUT=15, ack never asserted.
  - Response: cdc_req_o high 16 cycles, err_o pulses once, xfer_cnt_o unchanged, block returns to IDLE.
- Stale ack:
  - Stimulus: cdc_ack_i held high with req_i!=0.
  - Response: no gnt_o until ack_s falls; launch occurs 1 edge after ack_s=0.
- Reset mid-SEND:
  - Stimulus: assert arstn while in SEND.
  - Response: cdc_req_o=0 asynchronously; after release, req 0 wins first if all requesters are active.
